tdm_demux_8ch: RTL and testbench
================================

# tdm_demux_8ch

Time-division demultiplexer: the receiving end of an 8:1 multiplexer whose select lines S2..S0 are driven by a free-running slot counter. It samples one serial bit per enabled clock and uses a frame-sync marker to align to slot 0. It reassembles each 8-slot frame into a parallel word, where slot k maps to bit k (S2S1S0 = k selects D_k), and publishes the word with a one-cycle valid strobe. It sits directly downstream of the gate-level 8:1 mux in the serial link path.

## Interface
- CHANNELS, 8, slots per frame; power of two, 2..16; slot width SW = $clog2(CHANNELS)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  slot enable; one slot is consumed per clk edge with en=1
- din  input  1  serial data (mux output Y)
- frame_sync  input  1  marks the current din as slot 0; qualified by en
- d_out  output  CHANNELS  last complete frame; d_out[k] = slot k
- frame_valid  output  1  one-cycle pulse: d_out holds a new frame
- slot  output  SW  slot index the next enabled sample will occupy
- locked  output  1  high in LOCKED state
- sync_err  output  1  one-cycle pulse on misplaced or missing frame_sync
- parity_err  output  1  one-cycle pulse on parity mismatch (0 unless TDM_PARITY_EN)

## Operation
- Reset values: d_out=0, frame_valid=0, slot=0, locked=0, sync_err=0, parity_err=0, state=HUNT, shift register=0.
- States are HUNT and LOCKED. Only en=1 edges act. With en=0, state, slot and shift register hold, and pulses drop.
- HUNT:
  - din is ignored until en=1 and frame_sync=1.
  - That edge stores din as slot 0, sets slot=1 and enters LOCKED.
  - No sync_err is raised in HUNT.
- LOCKED: each enabled edge stores din at index slot, then slot increments.
- Frame completion:
  - Occurs when slot = CHANNELS-1 is sampled.
  - d_out is loaded with the full frame, including the current din.
  - frame_valid=1 in the next cycle. slot wraps to 0.
- Expected sync is slot 0 of every frame. The following cases apply at the enabled edge where slot==0:
  - frame_sync=1: normal.
  - frame_sync=0: sync_err pulses, the sample is discarded, state→HUNT, slot=0.
- Misplaced sync (frame_sync=1 while slot≠0 in LOCKED):
  - sync_err pulses and the partial frame is discarded. d_out is unchanged and frame_valid is not asserted.
  - din is stored as slot 0, slot=1, and state stays LOCKED.
- Async reset mid-frame discards the partial frame. All outputs take their reset values immediately.

## Timing
- din and frame_sync are sampled on the rising edge of clk.
- Latency: frame_valid and the new d_out appear in the cycle after the edge that sampled the last slot.
- frame_valid, sync_err and parity_err are each exactly one cycle wide, even if en stays low afterwards.
- d_out stays stable until the next completed frame.
- Back-to-back frames, i.e. CHANNELS consecutive enabled cycles, produce one frame_valid every CHANNELS cycles with no gap.
- slot and locked are registered, and reflect the state after the most recent edge.

## Configuration
- TDM_PARITY_EN: the frame is CHANNELS+1 slots.
  - Slot CHANNELS carries the even parity of the data slots.
  - On sampling that slot, d_out and frame_valid update as normal.
  - parity_err pulses in the same cycle as frame_valid if the XOR of data and parity is 1.
  - slot counts 0..CHANNELS, using width SW+1.
- Without the macro, the frame is CHANNELS slots and parity_err is tied to 0.

## Structure
- Package tdm_pkg holds:
  - the state enum (HUNT, LOCKED);
  - the default CHANNELS constant;
  - the function deriving slot width and frame length, including the parity slot.
- Sub-module tdm_slot_counter covers the slot counter, wrap logic and the expected-sync compare. It outputs slot, last_slot and sync_ok.
- The top level holds the FSM, the shift register, the output register and the pulse logic.

## Test plan
- Reset mid-frame: assert rst_n=0 after 3 slots → d_out=0, slot=0, locked=0 immediately. Then send sync + frame 8'hA5 → frame_valid once, d_out=8'hA5.
- Continuous frames 8'h01, 8'h80, 8'h3C with sync on each slot 0 → three frame_valid pulses spaced 8 cycles apart, with d_out following those values and sync_err never asserted.
- Exhaustive: all 256 frames, i.e. slot k=bit k as produced by an 8:1 mux driven by a counter → d_out matches each frame.
- Misplaced sync at slot 4 → sync_err pulse, no frame_valid. The next 8 slots 8'h5A → d_out=8'h5A.
- Missing sync at the expected slot 0 → sync_err, locked=0. din toggling without sync → no frame_valid.
- en gaps of 2 cycles inside a frame → the frame is still assembled correctly and frame_valid is one cycle wide.
- With TDM_PARITY_EN, frame 8'h07 followed by parity bit 0 → parity_err=1, frame_valid=1, d_out=8'h07.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared state type and frame sizing helpers for the TDM demultiplexer.
// Build with TDM_PARITY_EN defined to append an even-parity slot to each frame.
// No datapath here; sizing only.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int CHANNELS_DEFAULT = 8;

`ifdef TDM_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Slots per frame, including the trailing parity slot when enabled.
    function automatic int frame_len(input int ch);
        return ch + (PARITY_EN ? 1 : 0);
    endfunction

    function automatic int slot_w(input int ch);
        return (frame_len(ch) > 1) ? $clog2(frame_len(ch)) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index tracker: wraps at end of frame, restarts on frame_sync, flags sync position.
// Latency: slot registered, updates on each en=1 edge; last_slot/sync_ok are combinational.
// Backpressure: none; en=0 holds the count.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter  int CHANNELS = CHANNELS_DEFAULT,
    localparam int FL       = frame_len(CHANNELS),
    localparam int SLW      = slot_w(CHANNELS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           frame_sync,
    input  logic           locked,
    output logic [SLW-1:0] slot,
    output logic           last_slot,
    output logic           sync_ok
);

    logic at_zero;

    assign at_zero   = (slot == '0);
    assign last_slot = (slot == SLW'(FL - 1));
    // Sync must appear exactly at slot 0 and nowhere else.
    assign sync_ok   = (frame_sync == at_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (en) begin
            if (frame_sync)
                slot <= SLW'(1);
            else if (!locked || at_zero || last_slot)
                slot <= '0;
            else
                slot <= slot + SLW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux_8ch.sv
// Serial-to-parallel TDM demux: aligns on frame_sync, publishes each frame on d_out. Option: TDM_PARITY_EN.
// Latency: d_out/frame_valid one cycle after the edge sampling the last slot.
// Backpressure: none; en=0 stalls sampling, pulses still last exactly one cycle.
module tdm_demux_8ch
    import tdm_pkg::*;
#(
    parameter  int CHANNELS = CHANNELS_DEFAULT,
    localparam int FL       = frame_len(CHANNELS),
    localparam int SLW      = slot_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                din,
    input  logic                frame_sync,
    output logic [CHANNELS-1:0] d_out,
    output logic                frame_valid,
    output logic [SLW-1:0]      slot,
    output logic                locked,
    output logic                sync_err,
    output logic                parity_err
);

    state_t        state;
    logic [FL-1:0] sreg;
    logic [FL-1:0] frame_w;
    logic          last_slot;
    logic          sync_ok;

    assign locked = (state == LOCKED);

    tdm_slot_counter #(.CHANNELS(CHANNELS)) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .frame_sync (frame_sync),
        .locked     (locked),
        .slot       (slot),
        .last_slot  (last_slot),
        .sync_ok    (sync_ok)
    );

    // Frame contents including the bit being sampled this edge.
    always_comb begin
        frame_w = sreg;
        for (int i = 0; i < FL; i++) begin
            if (slot == SLW'(i))
                frame_w[i] = din;
        end
    end

`ifdef TDM_PARITY_EN
    logic par_err_q;
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            sreg        <= '0;
            d_out       <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            if (en) begin
                case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            state <= LOCKED;
                            sreg  <= FL'(din);
                        end
                    end
                    LOCKED: begin
                        if (!sync_ok) begin
                            sync_err <= 1'b1;
                            // Early sync restarts the frame; missing sync drops lock.
                            if (frame_sync) begin
                                sreg <= FL'(din);
                            end else begin
                                state <= HUNT;
                                sreg  <= '0;
                            end
                        end else if (last_slot) begin
                            d_out       <= frame_w[CHANNELS-1:0];
                            frame_valid <= 1'b1;
                            sreg        <= '0;
`ifdef TDM_PARITY_EN
                            par_err_q   <= ^frame_w;
`endif
                        end else begin
                            sreg <= frame_w;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Bench for tdm_demux_8ch: table-driven frames plus hand sequences, scoreboard on frame_valid.
module tb_tdm_demux_8ch;
    import tdm_pkg::*;

`ifdef TDM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int CH  = 8;
    localparam int FL  = frame_len(CH);
    localparam int SLW = slot_w(CH);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           din;
    logic           frame_sync;
    logic [CH-1:0]  d_out;
    logic           frame_valid;
    logic [SLW-1:0] slot;
    logic           locked;
    logic           sync_err;
    logic           parity_err;

    tdm_demux_8ch #(.CHANNELS(CH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .din         (din),
        .frame_sync  (frame_sync),
        .d_out       (d_out),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dout;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] frame;
        logic [7:0] exp_dout;
        bit         gap;
    } vec_t;

    exp_t sb[$];
    int   fv_cyc[$];
    int   passed = 0;
    int   total  = 0;
    int   fv_cnt = 0;
    int   se_cnt = 0;
    int   cyc    = 0;
    logic prev_fv = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        else
            passed++;
    endtask

    task automatic drive(input logic e, input logic d, input logic s);
        en = e;
        din = d;
        frame_sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Serial stream as produced by an 8:1 mux whose selects follow the slot count.
    task automatic send_frame(input logic [7:0] f, input logic [7:0] exp_d,
                              input bit gap, input bit bad_par);
        exp_t e;
        e.dout = exp_d;
        e.perr = PAR ? bad_par : 1'b0;
        sb.push_back(e);
        for (int k = 0; k < FL; k++) begin
            if (gap && k == 4) begin
                drive(1'b0, 1'b1, 1'b0);
                check("gap_slot_hold", 32'(slot), 32'd4);
                drive(1'b0, 1'b0, 1'b1);
                check("gap_lock_hold", 32'(locked), 32'd1);
            end
            if (k < CH) drive(1'b1, f[k], k == 0);
            else        drive(1'b1, (^f) ^ bad_par, 1'b0);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid) begin
                exp_t e;
                fv_cnt++;
                fv_cyc.push_back(cyc);
                check("fv_one_cycle", 32'(prev_fv), 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL fv_unexpected: got frame_valid with d_out=%0h, required none", d_out);
                end else begin
                    e = sb.pop_front();
                    check("sb_dout", 32'(d_out), 32'(e.dout));
                    check("sb_parity_err", 32'(parity_err), 32'(e.perr));
                end
            end else if (parity_err) begin
                total++;
                $display("FAIL perr_alone: got parity_err=1 without frame_valid, required 0");
            end
            if (sync_err) se_cnt++;
            prev_fv = frame_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[6];
        int         n0;
        int         se0;
        logic [7:0] v;

        tbl[0] = '{frame: 8'h01, exp_dout: 8'h01, gap: 1'b0};
        tbl[1] = '{frame: 8'h80, exp_dout: 8'h80, gap: 1'b0};
        tbl[2] = '{frame: 8'h3C, exp_dout: 8'h3C, gap: 1'b0};
        tbl[3] = '{frame: 8'hFF, exp_dout: 8'hFF, gap: 1'b1};
        tbl[4] = '{frame: 8'h00, exp_dout: 8'h00, gap: 1'b1};
        tbl[5] = '{frame: 8'h96, exp_dout: 8'h96, gap: 1'b1};

        rst_n = 1'b0; en = 1'b0; din = 1'b0; frame_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_d_out", 32'(d_out), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Reset mid-frame
        send_frame(8'hC3, 8'hC3, 1'b0, 1'b0);
        idle(2);
        check("pre_reset_frame", 32'(d_out), 32'hC3);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_d_out", 32'(d_out), 32'd0);
        check("midrst_slot", 32'(slot), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        #1 rst_n = 1'b1;
        n0 = fv_cnt;
        send_frame(8'hA5, 8'hA5, 1'b0, 1'b0);
        idle(2);
        check("after_rst_fv_count", 32'(fv_cnt - n0), 32'd1);
        check("after_rst_d_out", 32'(d_out), 32'hA5);
        check("after_rst_sb_empty", 32'(sb.size()), 32'd0);

        // Table: back-to-back frames, then frames with en gaps
        n0 = fv_cnt;
        se0 = se_cnt;
        fv_cyc.delete();
        for (int i = 0; i < 6; i++)
            send_frame(tbl[i].frame, tbl[i].exp_dout, tbl[i].gap, 1'b0);
        idle(3);
        check("tbl_fv_count", 32'(fv_cnt - n0), 32'd6);
        check("tbl_no_sync_err", 32'(se_cnt - se0), 32'd0);
        check("tbl_spacing_01", 32'(fv_cyc[1] - fv_cyc[0]), 32'(FL));
        check("tbl_spacing_12", 32'(fv_cyc[2] - fv_cyc[1]), 32'(FL));
        check("tbl_d_out_hold", 32'(d_out), 32'h96);
        check("tbl_sb_empty", 32'(sb.size()), 32'd0);

        // Exhaustive frames
        n0 = fv_cnt;
        se0 = se_cnt;
        for (int i = 0; i < 256; i++)
            send_frame(8'(i), 8'(i), 1'b0, 1'b0);
        idle(2);
        check("exh_fv_count", 32'(fv_cnt - n0), 32'd256);
        check("exh_no_sync_err", 32'(se_cnt - se0), 32'd0);
        check("exh_sb_empty", 32'(sb.size()), 32'd0);

        // Misplaced sync at slot 4
        n0 = fv_cnt;
        se0 = se_cnt;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("mis_slot_before", 32'(slot), 32'd4);
        v = 8'h5A;
        sb.push_back('{dout: v, perr: 1'b0});
        drive(1'b1, v[0], 1'b1);
        check("mis_sync_err", 32'(sync_err), 32'd1);
        check("mis_slot_restart", 32'(slot), 32'd1);
        check("mis_locked", 32'(locked), 32'd1);
        check("mis_d_out_kept", 32'(d_out), 32'hFF);
        for (int k = 1; k < FL; k++) begin
            if (k < CH) drive(1'b1, v[k], 1'b0);
            else        drive(1'b1, ^v, 1'b0);
        end
        idle(2);
        check("mis_fv_count", 32'(fv_cnt - n0), 32'd1);
        check("mis_sync_err_count", 32'(se_cnt - se0), 32'd1);
        check("mis_d_out", 32'(d_out), 32'h5A);
        check("mis_sb_empty", 32'(sb.size()), 32'd0);

        // Missing sync at expected slot 0
        n0 = fv_cnt;
        se0 = se_cnt;
        drive(1'b1, 1'b1, 1'b0);
        check("miss_sync_err", 32'(sync_err), 32'd1);
        check("miss_locked", 32'(locked), 32'd0);
        check("miss_slot", 32'(slot), 32'd0);
        for (int k = 0; k < 20; k++) drive(1'b1, k[0], 1'b0);
        idle(2);
        check("miss_no_fv", 32'(fv_cnt - n0), 32'd0);
        check("miss_one_sync_err", 32'(se_cnt - se0), 32'd1);
        check("miss_still_hunt", 32'(locked), 32'd0);
        check("miss_d_out_kept", 32'(d_out), 32'h5A);

`ifdef TDM_PARITY_EN
        n0 = fv_cnt;
        send_frame(8'h07, 8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 8'h07, 1'b0, 1'b0);
        idle(2);
        check("par_fv_count", 32'(fv_cnt - n0), 32'd2);
        check("par_sb_empty", 32'(sb.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
